// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot ROM loader.
// State encoding, ROM geometry and state-class helpers.
package rom_loader_pkg;

    localparam int ROM_DEPTH = 4096;
    localparam int ROM_AW    = 12;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_LO = 3'd1,
        CNT_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    function automatic logic takes_byte(input state_t s);
        return (s == CNT_LO) || (s == CNT_HI) ||
               (s == DATA)   || (s == CSUM);
    endfunction

    function automatic logic is_quiet(input state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/rom_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words
// and keeps the running XOR checksum of all data bytes.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [1:0]  k_q;
    logic [31:0] word_q;
    logic [7:0]  csum_q;

    // word already includes the byte being accepted this cycle
    always_comb begin
        word = word_q;
        word[8*k_q +: 8] = byte_in;
    end

    assign word_valid = byte_en && (k_q == 2'd3);
    assign csum       = csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= 2'd0;
            word_q <= 32'd0;
            csum_q <= 8'd0;
        end else if (clear) begin
            k_q    <= 2'd0;
            word_q <= 32'd0;
            csum_q <= 8'd0;
        end else if (byte_en) begin
            k_q    <= k_q + 2'd1;
            word_q <= word;
            csum_q <= csum_q ^ byte_in;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Boot-channel ROM loader: byte stream in, ROM write port out,
// CPU held in reset while a session is in flight.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int          MEM_NUM   = ROM_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        w_en_o,
    output logic [31:0] w_addr_o,
    output logic [31:0] w_data_o,
    output logic        hold_o,
    output logic        done_o,
    output logic        err_o
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   n_full;
    logic               accept;
    logic               clear;
    logic               byte_en;
    logic               word_valid;
    logic [31:0]        word;
    logic [7:0]         csum;
    logic               w_en_q;
    logic [31:0]        w_addr_q;
    logic [31:0]        w_data_q;

    assign rx_ready_o = takes_byte(state_q);
    assign accept     = rx_valid_i && rx_ready_o;
    assign clear      = start_i && is_quiet(state_q);
    assign byte_en    = accept && (state_q == DATA);
    assign n_full     = {rx_data_i, cnt_q[7:0]};

    assign hold_o   = !((state_q == IDLE) || (state_q == DONE));
    assign done_o   = (state_q == DONE);
    assign err_o    = (state_q == ERR);
    assign w_en_o   = w_en_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .byte_en    (byte_en),
        .byte_in    (rx_data_i),
        .word_valid (word_valid),
        .word       (word),
        .csum       (csum)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_d = CNT_LO;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    cnt_d   = {8'd0, rx_data_i};
                    state_d = CNT_HI;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    cnt_d = n_full;
                    // 17-bit compare so MEM_NUM = 65536 would still work
                    if ((n_full == '0) ||
                        ({1'b0, n_full} > 17'(MEM_NUM)))
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (word_valid)
                    state_d = WRITE;
            end
            WRITE: begin
                idx_d = idx_q + 16'd1;
                if (idx_q == cnt_q - 16'd1)
                    state_d = CSUM;
                else
                    state_d = DATA;
            end
            CSUM: begin
                if (accept)
                    state_d = (rx_data_i == csum) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Write port is loaded on the 4th byte so it is flat across WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en_q   <= 1'b0;
            w_addr_q <= 32'd0;
            w_data_q <= 32'd0;
        end else begin
            w_en_q <= (state_d == WRITE);
            if (state_q == DATA && word_valid) begin
                w_addr_q <= BASE_ADDR + {14'd0, idx_q, 2'b00};
                w_data_q <= word;
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: expected ROM writes are queued
// as the stream is built and popped when w_en_o fires.
module tb_rom_loader;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        w_en_o;
    logic [31:0] w_addr_o;
    logic [31:0] w_data_o;
    logic        hold_o;
    logic        done_o;
    logic        err_o;

    int          n_tests;
    int          n_fail;
    logic [63:0] exp_q[$];
    logic [7:0]  bq[$];
    logic [31:0] last_addr;

    rom_loader #(
        .MEM_NUM   (4096),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .rx_ready_o (rx_ready_o),
        .w_en_o     (w_en_o),
        .w_addr_o   (w_addr_o),
        .w_data_o   (w_data_o),
        .hold_o     (hold_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && w_en_o) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_addr", w_addr_o, e[63:32]);
                check("wr_data", w_data_o, e[31:0]);
            end
            check("rdy_in_write", {31'd0, rx_ready_o}, 32'd0);
            last_addr = w_addr_o;
        end
    end

    function automatic logic [31:0] gen_word(input int i);
        if (i == 0) return 32'h0000_0013;
        if (i == 1) return 32'h0010_0093;
        return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    task automatic build(input int n, input bit bad);
        logic [7:0]  cs;
        logic [31:0] w;
        logic [15:0] nn;
        bq.delete();
        nn = n[15:0];
        bq.push_back(nn[7:0]);
        bq.push_back(nn[15:8]);
        cs = 8'd0;
        for (int i = 0; i < n; i++) begin
            w = gen_word(i);
            exp_q.push_back({32'(i) << 2, w});
            for (int j = 0; j < 4; j++) begin
                bq.push_back(w[8*j +: 8]);
                cs = cs ^ w[8*j +: 8];
            end
        end
        bq.push_back(bad ? (cs ^ 8'h01) : cs);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        while (!rx_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready_o) begin
            check("rx_timeout", 32'd0, 32'd1);
            rx_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_all(input int gap);
        foreach (bq[i]) begin
            send_byte(bq[i]);
            if (gap > 0) begin
                rx_valid_i = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic expect_end(input string tag, input bit ok);
        @(negedge clk);
        check({tag, "_done"}, {31'd0, done_o}, {31'd0, ok});
        check({tag, "_err"},  {31'd0, err_o},  {31'd0, !ok});
        check({tag, "_hold"}, {31'd0, hold_o}, {31'd0, !ok});
        check({tag, "_rdy"},  {31'd0, rx_ready_o}, 32'd0);
        check({tag, "_qleft"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        last_addr  = 32'd0;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_hold", {31'd0, hold_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_err",  {31'd0, err_o},  32'd0);
        check("rst_wen",  {31'd0, w_en_o}, 32'd0);
        check("rst_rdy",  {31'd0, rx_ready_o}, 32'd0);
        check("rst_addr", w_addr_o, 32'd0);
        check("rst_data", w_data_o, 32'd0);
        rst_n = 1'b1;

        // basic load with idle gaps between bytes
        pulse_start();
        check("busy_hold", {31'd0, hold_o}, 32'd1);
        build(2, 1'b0);
        send_all(1);
        expect_end("basic", 1'b1);

        // zero count
        pulse_start();
        bq = '{8'h00, 8'h00};
        send_all(0);
        expect_end("zero", 1'b0);

        // N = 4097
        pulse_start();
        bq = '{8'h01, 8'h10};
        send_all(0);
        expect_end("over", 1'b0);

        // N = 4096 with rx_valid held high throughout
        pulse_start();
        build(4096, 1'b0);
        send_all(0);
        expect_end("full", 1'b1);
        check("full_last_addr", last_addr, 32'h0000_3FFC);

        // bad checksum, then a clean retry
        pulse_start();
        build(2, 1'b1);
        send_all(0);
        expect_end("badcs", 1'b0);
        pulse_start();
        build(2, 1'b0);
        send_all(0);
        expect_end("retry", 1'b1);

        // reset after 6 data bytes
        pulse_start();
        build(2, 1'b0);
        void'(exp_q.pop_back());
        while (bq.size() > 8) void'(bq.pop_back());
        send_all(0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_hold", {31'd0, hold_o}, 32'd0);
        check("mrst_rdy",  {31'd0, rx_ready_o}, 32'd0);
        check("mrst_wen",  {31'd0, w_en_o}, 32'd0);
        check("mrst_addr", w_addr_o, 32'd0);
        check("mrst_data", w_data_o, 32'd0);
        check("mrst_qleft", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        build(2, 1'b0);
        send_all(0);
        expect_end("after_rst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
